// File: rtl/uart_pkg.sv
// Shared types and command-field helpers for the uart command arbiter.
package uart_pkg;

    localparam int CMD_ADDR_W_DEF = 7;
    localparam int CMD_DATA_W_DEF = 8;
    localparam int CMD_RW_FLAG_DEF = 1;
    localparam int CMD_DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } arb_state_e;

    function automatic int addr_lsb(input int data_w);
        return CMD_DATA_LSB + data_w;
    endfunction

    function automatic int rw_bit(input int addr_w, input int data_w);
        return addr_lsb(data_w) + addr_w;
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first request at or above ptr, then wrap.
module uart_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && i >= int'(ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && i < int'(ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arb.sv
// Round-robin arbiter sharing one uart command port among NUM_REQ masters.
// Define UART_ARB_TIMEOUT_EN to bound the wait for a read response.
module uart_cmd_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CMD_ADDR_WIDTH = CMD_ADDR_W_DEF,
    parameter int CMD_DATA_WIDTH = CMD_DATA_W_DEF,
    parameter int CMD_RW_FLAG    = CMD_RW_FLAG_DEF,
    parameter int CMD_WIDTH      = CMD_ADDR_WIDTH + CMD_DATA_WIDTH + CMD_RW_FLAG,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [CMD_DATA_WIDTH-1:0]    rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         m_cmd_valid,
    output logic [CMD_WIDTH-1:0]         m_cmd_data,
    input  logic                         m_cmd_ready,
    input  logic                         m_read_valid,
    input  logic [CMD_DATA_WIDTH-1:0]    m_read_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW_BIT = rw_bit(CMD_ADDR_WIDTH, CMD_DATA_WIDTH) + CMD_RW_FLAG - 1;

    arb_state_e state_q, state_d;
    logic [IW-1:0]        ptr_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   win_gnt;
    logic [IW-1:0]        win_idx;
    logic                 win_any;
    logic [CMD_WIDTH-1:0] win_cmd;
    logic                 tmo_exp;

    uart_rr_arb #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        win_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i))
                win_cmd = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state_q != ST_WAIT_RD)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_exp = (state_q == ST_WAIT_RD) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_exp = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    req_ready = win_gnt;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_cmd_ready)
                    state_d = m_cmd_data[RW_BIT] ? ST_IDLE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (m_read_valid || tmo_exp)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            m_cmd_valid <= 1'b0;
            m_cmd_data  <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= '0;
            if (state_q == ST_IDLE && win_any) begin
                m_cmd_data  <= win_cmd;
                m_cmd_valid <= 1'b1;
                grant_q     <= win_gnt;
                ptr_q       <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (state_q == ST_ISSUE && m_cmd_ready)
                m_cmd_valid <= 1'b0;
            // A response arriving on the expiry cycle beats the timeout.
            if (state_q == ST_WAIT_RD) begin
                if (m_read_valid) begin
                    rsp_valid <= grant_q;
                    rsp_data  <= m_read_data;
                    rsp_err   <= 1'b0;
                end else if (tmo_exp) begin
                    rsp_valid <= grant_q;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_arb.sv
// Directed self-checking bench for uart_cmd_arb (TIMEOUT_CYCLES=100).
module tb_uart_cmd_arb;

    localparam int N = 4;
    localparam int CW = 16;
    localparam int DW = 8;
    localparam int TMO = 100;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            m_cmd_valid;
    logic [CW-1:0]   m_cmd_data;
    logic            m_cmd_ready;
    logic            m_read_valid;
    logic [DW-1:0]   m_read_data;

    int n_chk;
    int n_fail;

    uart_cmd_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .m_cmd_valid  (m_cmd_valid),
        .m_cmd_data   (m_cmd_data),
        .m_cmd_ready  (m_cmd_ready),
        .m_read_valid (m_read_valid),
        .m_read_data  (m_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int acc_ord[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [CW-1:0] held;

    initial begin
        n_chk = 0;
        n_fail = 0;
        req_valid = '0;
        req_cmd = '0;
        m_cmd_ready = 1'b0;
        m_read_valid = 1'b0;
        m_read_data = '0;
        do_reset();

        check("rst_cmd_valid", 32'(m_cmd_valid), 32'd0);
        check("rst_cmd_data", 32'(m_cmd_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: write from req0
        req_cmd[0*CW +: CW] = 16'hE4AB;
        req_valid = 4'b0001;
        #1 check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t1_valid", 32'(m_cmd_valid), 32'd1);
        check("t1_data", 32'(m_cmd_data), 32'hE4AB);
        check("t1_ready_busy", 32'(req_ready), 32'd0);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_valid_low", 32'(m_cmd_valid), 32'd0);
        check("t1_no_rsp", 32'(rsp_valid), 32'd0);

        // 2: read from req2
        req_cmd[2*CW +: CW] = 16'h6400;
        req_valid = 4'b0100;
        #1 check("t2_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("t2_data", 32'(m_cmd_data), 32'h6400);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("t2_wait_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("t2_no_rsp_yet", 32'(rsp_valid), 32'd0);
        m_read_valid = 1'b1;
        m_read_data = 8'h35;
        tick();
        m_read_valid = 1'b0;
        check("t2_rsp_valid", 32'(rsp_valid), 32'h4);
        check("t2_rsp_data", 32'(rsp_data), 32'h35);
        check("t2_rsp_err", 32'(rsp_err), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);
        tick();
        check("t2_pulse", 32'(rsp_valid), 32'd0);

        // 3: all four writing, fairness from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++)
            req_cmd[i*CW +: CW] = {1'b1, 7'(i + 1), 8'(16 * i + 1)};
        req_valid = 4'b1111;
        m_cmd_ready = 1'b1;
        for (int c = 0; c < 20 && acc_ord.size() < 5; c++) begin
            #1;
            for (int i = 0; i < N; i++)
                if (req_ready[i]) acc_ord.push_back(i);
            tick();
        end
        req_valid = '0;
        check("t3_count", 32'(acc_ord.size()), 32'd5);
        for (int k = 0; k < 5 && k < acc_ord.size(); k++)
            check($sformatf("t3_order%0d", k), 32'(acc_ord[k]), 32'(exp_ord[k]));
        tick();
        m_cmd_ready = 1'b0;
        check("t3_idle", 32'(busy), 32'd0);

        // 4: stall with ready low
        req_cmd[1*CW +: CW] = 16'hC255;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        held = 16'hC255;
        for (int c = 0; c < 20; c++) begin
            check("t4_valid", 32'(m_cmd_valid), 32'd1);
            check("t4_data", 32'(m_cmd_data), 32'(held));
            check("t4_ready0", 32'(req_ready), 32'd0);
            check("t4_busy", 32'(busy), 32'd1);
            req_valid = 4'b1111;
            tick();
            req_valid = '0;
        end
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("t4_idle", 32'(busy), 32'd0);

        // 5: read from req1 with no response
        req_cmd[1*CW +: CW] = 16'h2A00;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        for (int c = 1; c < TMO; c++) tick();
        check("t5_before", 32'(rsp_valid), 32'd0);
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        check("t5_tmo_valid", 32'(rsp_valid), 32'h2);
        check("t5_tmo_err", 32'(rsp_err), 32'd1);
        check("t5_tmo_data", 32'(rsp_data), 32'd0);
        check("t5_tmo_idle", 32'(busy), 32'd0);
`else
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
`endif

        // 6: reset in WAIT_RD, late read_valid ignored
        do_reset();
        req_cmd[3*CW +: CW] = 16'h1100;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("t6_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_valid", 32'(m_cmd_valid), 32'd0);
        check("t6_rst_data", 32'(m_cmd_data), 32'd0);
        rst_n = 1'b1;
        m_read_valid = 1'b1;
        m_read_data = 8'h77;
        tick();
        m_read_valid = 1'b0;
        tick();
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        check("t6_no_data", 32'(rsp_data), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
